ibex_register_file_ckpt: RTL and testbench

Parametrised flip-flop register file with an on-chip checkpoint bank and a multi-cycle rollback engine, used by the lockstep core pair for error recovery. On request it snapshots every architectural register into the checkpoint bank in one cycle. After a comparator mismatch it restores the registers from that snapshot, `RestoreLanes` words per cycle. It keeps the one-shot corrupt-on-command (CTC) fault-injection hook. It replaces the shadow-port exchange between main and shadow register files with a self-contained checkpoint per instance.

---
 rtl/ibex_rf_ckpt_pkg.sv | 7 +
 rtl/ibex_rf_restore_ctrl.sv | 65 ++++++
 rtl/ibex_register_file_ckpt.sv | 88 ++++++++
 tb/tb_ibex_register_file_ckpt.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rf_ckpt_pkg.sv
// ibex_rf_ckpt_pkg: shared FSM encoding and sizing helper for the checkpointed register file
package ibex_rf_ckpt_pkg;
  typedef enum logic [1:0] {IDLE, RESTORE, DONE} rf_ckpt_state_e;
  function automatic int RfCkptBlkW(input int num_words, input int lanes);
    return (num_words / lanes > 1) ? $clog2(num_words / lanes) : 1;
  endfunction
endpackage

// File: rtl/ibex_rf_restore_ctrl.sv
// ibex_rf_restore_ctrl: rollback FSM, block counter and request legality checking
module ibex_rf_restore_ctrl import ibex_rf_ckpt_pkg::*; #(
  parameter int NumBlks = 8,
  parameter int BlkW    = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic               ckpt_req_i,
  input  logic               rollback_req_i,
  input  logic               ckpt_valid_i,
  output logic               busy_o,
  output logic               we_en_o,
  output logic               ckpt_en_o,
  output logic [NumBlks-1:0] restore_en_o,
  output logic               rollback_done_o,
  output logic               err_o
);
  rf_ckpt_state_e  r_state, w_state_d;
  logic [BlkW-1:0] r_blk, w_blk_d;
  logic            r_done, r_err;
  logic            w_idle, w_rb_ok, w_err_d;
  assign w_idle    = r_state == IDLE;
  assign w_rb_ok   = w_idle & rollback_req_i & ckpt_valid_i;
  assign busy_o    = ~w_idle;
  assign we_en_o   = w_idle & we_i;
  // an accepted rollback wins over a same-cycle checkpoint
  assign ckpt_en_o = w_idle & ckpt_req_i & ~w_rb_ok;
  assign w_err_d   = (busy_o & (we_i | ckpt_req_i | rollback_req_i)) |
                     (w_idle & rollback_req_i & (~ckpt_valid_i | ckpt_req_i));
  assign rollback_done_o = r_done;
  assign err_o           = r_err;
  for (genvar b = 0; b < NumBlks; b++) begin : g_en
    assign restore_en_o[b] = (r_state == RESTORE) && (r_blk == BlkW'(b));
  end
  always_comb begin
    w_state_d = r_state;
    w_blk_d   = r_blk;
    unique case (r_state)
      IDLE:    if (w_rb_ok) begin
                 w_state_d = RESTORE;
                 w_blk_d   = '0;
               end
      RESTORE: begin
                 w_blk_d   = r_blk + 1'b1;
                 w_state_d = (r_blk == BlkW'(NumBlks - 1)) ? DONE : RESTORE;
               end
      DONE:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_blk   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_blk   <= w_blk_d;
      r_done  <= w_state_d == DONE;
      r_err   <= w_err_d;
    end
  end
endmodule

// File: rtl/ibex_register_file_ckpt.sv
// ibex_register_file_ckpt: flop register file with a one-cycle checkpoint bank,
// multi-cycle rollback and a one-shot corrupt-on-command fault hook
module ibex_register_file_ckpt import ibex_rf_ckpt_pkg::*; #(
  parameter bit                   RV32E        = 1'b0,
  parameter int                   DataWidth    = 32,
  parameter int                   NumReadPorts = 2,
  parameter int                   RestoreLanes = 4,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumReadPorts-1:0][4:0]           raddr_i,
  output logic [NumReadPorts-1:0][DataWidth-1:0] rdata_o,
  input  logic [4:0]                             waddr_i,
  input  logic [DataWidth-1:0]                   wdata_i,
  input  logic                                   we_i,
  input  logic                                   ckpt_req_i,
  input  logic                                   rollback_req_i,
  input  logic                                   ctc_command_i,
  output logic                                   busy_o,
  output logic                                   ckpt_valid_o,
  output logic                                   rollback_done_o,
  output logic                                   err_o
);
  localparam int NUM_WORDS = RV32E ? 16 : 32;
  localparam int NUM_BLKS  = NUM_WORDS / RestoreLanes;
  localparam int BLK_W     = RfCkptBlkW(NUM_WORDS, RestoreLanes);
  logic [DataWidth-1:0] r_mem  [1:NUM_WORDS-1];
  logic [DataWidth-1:0] r_ckpt [1:NUM_WORDS-1];
  logic                 r_ckpt_valid, r_ctc_q, r_ctc_active;
  logic                 w_we_en, w_ckpt_en;
  logic [NUM_BLKS-1:0]  w_restore_en;
  logic [4:0]           w_waddr;
  logic [4:0]           w_raddr [NumReadPorts];
  ibex_rf_restore_ctrl #(.NumBlks(NUM_BLKS), .BlkW(BLK_W)) u_ctrl (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .we_i            (we_i),
    .ckpt_req_i      (ckpt_req_i),
    .rollback_req_i  (rollback_req_i),
    .ckpt_valid_i    (r_ckpt_valid),
    .busy_o          (busy_o),
    .we_en_o         (w_we_en),
    .ckpt_en_o       (w_ckpt_en),
    .restore_en_o    (w_restore_en),
    .rollback_done_o (rollback_done_o),
    .err_o           (err_o)
  );
  assign ckpt_valid_o = r_ckpt_valid;
  assign w_waddr      = RV32E ? {1'b0, waddr_i[3:0]} : waddr_i;
  for (genvar p = 0; p < NumReadPorts; p++) begin : g_ra
    assign w_raddr[p] = RV32E ? {1'b0, raddr_i[p][3:0]} : raddr_i[p];
  end
  always_comb begin
    for (int p = 0; p < NumReadPorts; p++) begin
      rdata_o[p] = WordZeroVal;
      for (int w = 1; w < NUM_WORDS; w++)
        if (w_raddr[p] == 5'(w)) rdata_o[p] = r_mem[w];
    end
  end
  // restore beats the fault hook, which beats a normal write; the snapshot sees pre-edge values
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int w = 1; w < NUM_WORDS; w++) begin
        r_mem[w]  <= WordZeroVal;
        r_ckpt[w] <= WordZeroVal;
      end
    end else begin
      for (int w = 1; w < NUM_WORDS; w++) begin
        if (w_restore_en[BLK_W'(w / RestoreLanes)]) r_mem[w] <= r_ckpt[w];
        else if (r_ctc_active)                      r_mem[w] <= ~r_mem[w];
        else if (w_we_en && w_waddr == 5'(w))       r_mem[w] <= wdata_i;
        if (w_ckpt_en) r_ckpt[w] <= r_mem[w];
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ckpt_valid <= 1'b0;
      r_ctc_q      <= 1'b0;
      r_ctc_active <= 1'b0;
    end else begin
      r_ckpt_valid <= r_ckpt_valid | w_ckpt_en;
      r_ctc_q      <= ctc_command_i;
      r_ctc_active <= ctc_command_i & ~r_ctc_q;
    end
  end
endmodule

// File: tb/tb_ibex_register_file_ckpt.sv
// tb_ibex_register_file_ckpt: default and RV32E/8-lane instances driven in parallel
// and compared each cycle against an array-based behavioural model
module tb_ibex_register_file_ckpt;
  logic            clk = 1'b0;
  logic            rst, we, ckq, rbq, ctc;
  logic [1:0][4:0] ra;
  logic [4:0]      wa;
  logic [31:0]     wd;
  logic [1:0][31:0] rd_a, rd_b;
  logic busy_a, valid_a, done_a, err_a, busy_b, valid_b, done_b, err_b;
  always #5 clk = ~clk;
  ibex_register_file_ckpt u_a (
    .clk_i(clk), .rst_i(rst), .raddr_i(ra), .rdata_o(rd_a), .waddr_i(wa), .wdata_i(wd),
    .we_i(we), .ckpt_req_i(ckq), .rollback_req_i(rbq), .ctc_command_i(ctc),
    .busy_o(busy_a), .ckpt_valid_o(valid_a), .rollback_done_o(done_a), .err_o(err_a));
  ibex_register_file_ckpt #(.RV32E(1'b1), .RestoreLanes(8)) u_b (
    .clk_i(clk), .rst_i(rst), .raddr_i(ra), .rdata_o(rd_b), .waddr_i(wa), .wdata_i(wd),
    .we_i(we), .ckpt_req_i(ckq), .rollback_req_i(rbq), .ctc_command_i(ctc),
    .busy_o(busy_b), .ckpt_valid_o(valid_b), .rollback_done_o(done_b), .err_o(err_b));
  int n_vec = 0, n_bad = 0;
  int nw [2] = '{32, 16};
  int ln [2] = '{4, 8};
  logic [31:0] mm [2][32];
  logic [31:0] mk [2][32];
  int bl [2];
  bit mv [2], mdone [2], merr [2], mact [2], mprev [2];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int amask(input int i, input logic [4:0] a);
    return nw[i] == 16 ? int'(a[3:0]) : int'(a);
  endfunction
  function automatic logic [31:0] mread(input int i, input logic [4:0] a);
    int x = amask(i, a);
    return x == 0 ? 32'h0 : mm[i][x];
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32; w++) begin
        mm[i][w] = '0;
        mk[i][w] = '0;
      end
      bl[i] = 0; mv[i] = 0; mdone[i] = 0; merr[i] = 0; mact[i] = 0; mprev[i] = 0;
    end
  endtask
  // one clock edge: bl counts remaining busy cycles (restore blocks plus the done cycle)
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] nm [32];
      bit busy = bl[i] != 0;
      bit rb_ok = !busy && rbq && mv[i];
      int nb = nw[i] / ln[i];
      int a = amask(i, wa);
      merr[i] = (busy && (we || ckq || rbq)) || (!busy && rbq && (!mv[i] || ckq));
      for (int w = 0; w < 32; w++) nm[w] = mm[i][w];
      if (!busy && we && a != 0) nm[a] = wd;
      if (mact[i]) for (int w = 1; w < nw[i]; w++) nm[w] = ~mm[i][w];
      if (busy && bl[i] > 1) begin
        int k = nb + 1 - bl[i];
        for (int j = 0; j < ln[i]; j++)
          if (k * ln[i] + j != 0) nm[k * ln[i] + j] = mk[i][k * ln[i] + j];
      end
      if (!busy && ckq && !rb_ok) begin
        for (int w = 0; w < 32; w++) mk[i][w] = mm[i][w];
        mv[i] = 1;
      end
      if (busy) bl[i]--;
      else if (rb_ok) bl[i] = nb + 1;
      mdone[i] = bl[i] == 1;
      for (int w = 0; w < 32; w++) mm[i][w] = nm[w];
      mact[i] = ctc && !mprev[i];
      mprev[i] = ctc;
    end
  endtask
  task automatic check_outs();
    check("busy_a", busy_a, bl[0] != 0);
    check("busy_b", busy_b, bl[1] != 0);
    check("valid_a", valid_a, mv[0]);
    check("valid_b", valid_b, mv[1]);
    check("done_a", done_a, mdone[0]);
    check("done_b", done_b, mdone[1]);
    check("err_a", err_a, merr[0]);
    check("err_b", err_b, merr[1]);
    check("rd_a0", rd_a[0], mread(0, ra[0]));
    check("rd_a1", rd_a[1], mread(0, ra[1]));
    check("rd_b0", rd_b[0], mread(1, ra[0]));
    check("rd_b1", rd_b[1], mread(1, ra[1]));
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; wa = a; wd = d;
    step();
    we = 0;
  endtask
  task automatic ckpt();
    ckq = 1;
    step();
    ckq = 0;
  endtask
  task automatic rb_wait();
    rbq = 1;
    step();
    rbq = 0;
    repeat (10) step();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int na, nb;
    rst = 1; we = 0; ckq = 0; rbq = 0; ctc = 0; wa = '0; wd = '0; ra = '0;
    model_reset();
    #7;
    check_outs();
    @(negedge clk);
    rst = 0;
    rbq = 1;
    step();
    rbq = 0;
    check("err_no_ckpt", err_a, 1'b1);
    check("busy_no_ckpt", busy_a, 1'b0);
    step();
    check("err_no_ckpt_clr", err_a, 1'b0);
    wr(5, 32'hA5A5_0001);
    ckpt();
    wr(5, 32'h0000_1234);
    ra[0] = 5;
    #1 check("x5_pre_rb", rd_a[0], 32'h0000_1234);
    rbq = 1; na = 0; nb = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      rbq = 0;
      if (done_a && na == 0) na = n;
      if (done_b && nb == 0) nb = n;
    end
    check("lat_a", na, 9);
    check("lat_b", nb, 3);
    check("x5_rb_a", rd_a[0], 32'hA5A5_0001);
    check("x5_rb_b", rd_b[0], 32'hA5A5_0001);
    wr(7, 32'h77);
    ckq = 1; we = 1; wa = 7; wd = 32'hFF;
    step();
    ckq = 0; we = 0;
    wr(7, 32'h99);
    ra[1] = 7;
    rb_wait();
    check("x7_rb", rd_a[1], 32'h77);
    wr(3, 32'h33);
    ckpt();
    rbq = 1;
    step();
    rbq = 0;
    repeat (2) step();
    we = 1; wa = 3; wd = 32'h55;
    step();
    we = 0;
    check("err_wr_busy", err_a, 1'b1);
    repeat (8) step();
    ra[0] = 3;
    #1 check("x3_rb", rd_a[0], 32'h33);
    wr(1, 32'h0000_000F);
    ckpt();
    ra[0] = 1; ra[1] = 0;
    ctc = 1;
    repeat (2) step();
    check("x1_inv", rd_a[0], 32'hFFFF_FFF0);
    check("x0_ctc", rd_a[1], 32'h0);
    repeat (3) step();
    check("x1_hold", rd_a[0], 32'hFFFF_FFF0);
    ctc = 0;
    rb_wait();
    check("x1_rb", rd_a[0], 32'h0000_000F);
    rbq = 1;
    step();
    rbq = 0;
    repeat (2) step();
    rst = 1;
    model_reset();
    #1;
    check("rst_valid", valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_x1", rd_a[0], 32'h0);
    check_outs();
    @(negedge clk);
    rst = 0;
    repeat (400) begin
      we  = ($urandom_range(1) == 1);
      ckq = ($urandom_range(7) == 0);
      rbq = ($urandom_range(15) == 0);
      if ($urandom_range(15) == 0) ctc = ~ctc;
      wa = 5'($urandom);
      wd = $urandom;
      ra[0] = 5'($urandom);
      ra[1] = 5'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
